num_entry_ctrl: RTL and testbench

//  Sequencer for two-digit keypad number entry. Collects operand A, then operand B,

---
 rtl/num_entry_ctrl_pkg.sv | 28 ++
 rtl/num_entry_ctrl_if.sv | 25 ++
 rtl/num_entry_ctrl_digit_accum.sv | 54 +++++
 rtl/num_entry_ctrl.sv | 129 ++++++++++++
 tb/tb_num_entry_ctrl.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/num_entry_ctrl_pkg.sv
// Shared constants and helpers for the two-operand keypad entry sequencer.
package num_entry_ctrl_pkg;

  localparam int NUM_BIT_WIDTH     = 4;
  localparam int NUM_OUT_BIT_WIDTH = 8;

  localparam logic [1:0] S_ENTER_A = 2'd0;
  localparam logic [1:0] S_ENTER_B = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

  localparam logic [NUM_BIT_WIDTH-1:0] KEY_ENTER = 4'hA;
  localparam logic [NUM_BIT_WIDTH-1:0] KEY_CLEAR = 4'hB;

  function automatic logic isDigit(input logic [NUM_BIT_WIDTH-1:0] code);
    return (code <= 4'd9);
  endfunction

  // tens*10 built from shifts so no multiplier is inferred; max result is 99.
  function automatic logic [NUM_OUT_BIT_WIDTH-1:0] bcdToBin(
    input logic [NUM_BIT_WIDTH-1:0] tens,
    input logic [NUM_BIT_WIDTH-1:0] unit
  );
    logic [NUM_OUT_BIT_WIDTH-1:0] tensExt;
    tensExt = {4'b0000, tens};
    return (tensExt << 3) + (tensExt << 1) + {4'b0000, unit};
  endfunction

endpackage

// File: rtl/num_entry_ctrl_if.sv
// Key-event input, operand handshake and display/debug outputs of num_entry_ctrl.
interface num_entry_ctrl_if;
  import num_entry_ctrl_pkg::*;

  logic                         key_valid;
  logic [NUM_BIT_WIDTH-1:0]     key_code;
  logic                         ops_ready;
  logic                         ops_valid;
  logic [NUM_OUT_BIT_WIDTH-1:0] op_a;
  logic [NUM_OUT_BIT_WIDTH-1:0] op_b;
  logic [NUM_BIT_WIDTH-1:0]     disp_tens;
  logic [NUM_BIT_WIDTH-1:0]     disp_unit;
  logic [1:0]                   state;
  logic                         key_err;

  modport master (
    output key_valid, key_code, ops_ready,
    input  ops_valid, op_a, op_b, disp_tens, disp_unit, state, key_err
  );

  modport slave (
    input  key_valid, key_code, ops_ready,
    output ops_valid, op_a, op_b, disp_tens, disp_unit, state, key_err
  );
endinterface

// File: rtl/num_entry_ctrl_digit_accum.sv
// Two-digit BCD shift register: new digits enter the units place, a third digit is refused.
module digit_accum
  import num_entry_ctrl_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear_i,
  input  logic                         load_i,
  input  logic [NUM_BIT_WIDTH-1:0]     digit_i,
  output logic [NUM_BIT_WIDTH-1:0]     tens_o,
  output logic [NUM_BIT_WIDTH-1:0]     unit_o,
  output logic [1:0]                   count_o,
  output logic                         full_o,
  output logic [NUM_OUT_BIT_WIDTH-1:0] value_o
);

  logic [NUM_BIT_WIDTH-1:0] tens_q, tens_d;
  logic [NUM_BIT_WIDTH-1:0] unit_q, unit_d;
  logic [1:0]               count_q, count_d;

  always_comb begin
    tens_d  = tens_q;
    unit_d  = unit_q;
    count_d = count_q;
    if (clear_i) begin
      tens_d  = '0;
      unit_d  = '0;
      count_d = 2'd0;
    end else if (load_i && (count_q != 2'd2)) begin
      tens_d  = (count_q == 2'd0) ? '0 : unit_q;
      unit_d  = digit_i;
      count_d = count_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tens_q  <= '0;
      unit_q  <= '0;
      count_q <= 2'd0;
    end else begin
      tens_q  <= tens_d;
      unit_q  <= unit_d;
      count_q <= count_d;
    end
  end

  assign tens_o  = tens_q;
  assign unit_o  = unit_q;
  assign count_o = count_q;
  assign full_o  = (count_q == 2'd2);
  assign value_o = bcdToBin(tens_q, unit_q);

endmodule

// File: rtl/num_entry_ctrl.sv
// Keypad operand sequencer: collects A then B, offers both with valid/ready, auto-clears when idle.
module num_entry_ctrl
  import num_entry_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100_000_000,
  parameter int TO_W           = 27
) (
  input  logic               clk,
  input  logic               rst_n,
  num_entry_ctrl_if.slave    bus
);

  logic [1:0]                   state_q, state_d;
  logic [NUM_OUT_BIT_WIDTH-1:0] opA_q, opA_d;
  logic [NUM_OUT_BIT_WIDTH-1:0] opB_q, opB_d;
  logic                         opsValid_q, opsValid_d;
  logic                         keyErr_q, keyErr_d;
  logic [TO_W-1:0]              timer_q, timer_d;

  logic                         accLoad, accClear, accFull;
  logic [1:0]                   accCount;
  logic [NUM_BIT_WIDTH-1:0]     accTens, accUnit;
  logic [NUM_OUT_BIT_WIDTH-1:0] accValue;

  logic transfer, inEntry, timerRun, timeoutHit, clearAll;

  digit_accum u_accum (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (accClear),
    .load_i  (accLoad),
    .digit_i (bus.key_code),
    .tens_o  (accTens),
    .unit_o  (accUnit),
    .count_o (accCount),
    .full_o  (accFull),
    .value_o (accValue)
  );

  // Idle timer only runs while something is partially entered; any key restarts it.
  always_comb begin
    transfer   = opsValid_q && bus.ops_ready;
    inEntry    = (state_q == S_ENTER_A) || (state_q == S_ENTER_B);
    timerRun   = ((state_q == S_ENTER_A) && (accCount != 2'd0)) || (state_q == S_ENTER_B);
    timeoutHit = (TIMEOUT_CYCLES != 0) && timerRun && !bus.key_valid &&
                 (timer_q == TO_W'(TIMEOUT_CYCLES - 1));
    clearAll   = (bus.key_valid && (bus.key_code == KEY_CLEAR)) || timeoutHit;
  end

  always_comb begin
    state_d    = state_q;
    opA_d      = opA_q;
    opB_d      = opB_q;
    opsValid_d = opsValid_q;
    keyErr_d   = 1'b0;
    accLoad    = 1'b0;
    accClear   = 1'b0;
    timer_d    = (bus.key_valid || !timerRun) ? '0 : timer_q + 1'b1;

    if (state_q == 2'd3) begin
      state_d = S_ENTER_A;
    end

    if (transfer) begin
      opsValid_d = 1'b0;
      state_d    = S_ENTER_A;
    end

    if (bus.key_valid && inEntry) begin
      if (isDigit(bus.key_code)) begin
        if (accFull) begin
          keyErr_d = 1'b1;
        end else begin
          accLoad = 1'b1;
        end
      end else if (bus.key_code == KEY_ENTER) begin
        accClear = 1'b1;
        if (state_q == S_ENTER_A) begin
          opA_d   = accValue;
          state_d = S_ENTER_B;
        end else begin
          opB_d      = accValue;
          state_d    = S_DONE;
          opsValid_d = 1'b1;
        end
      end else if (bus.key_code != KEY_CLEAR) begin
        keyErr_d = 1'b1;
      end
    end

    // CLEAR (or its timeout twin) overrides everything, including a same-cycle transfer.
    if (clearAll) begin
      accClear   = 1'b1;
      accLoad    = 1'b0;
      opA_d      = '0;
      opB_d      = '0;
      opsValid_d = 1'b0;
      state_d    = S_ENTER_A;
      timer_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_ENTER_A;
      opA_q      <= '0;
      opB_q      <= '0;
      opsValid_q <= 1'b0;
      keyErr_q   <= 1'b0;
      timer_q    <= '0;
    end else begin
      state_q    <= state_d;
      opA_q      <= opA_d;
      opB_q      <= opB_d;
      opsValid_q <= opsValid_d;
      keyErr_q   <= keyErr_d;
      timer_q    <= timer_d;
    end
  end

  assign bus.ops_valid = opsValid_q;
  assign bus.op_a      = opA_q;
  assign bus.op_b      = opB_q;
  assign bus.disp_tens = accTens;
  assign bus.disp_unit = accUnit;
  assign bus.state     = state_q;
  assign bus.key_err   = keyErr_q;

endmodule

// File: tb/tb_num_entry_ctrl.sv
// Directed and random key sequences checked against a digit-list reference model of the entry rules.
module tb_num_entry_ctrl;

  localparam int TO = 16;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  num_entry_ctrl_if bus ();

  num_entry_ctrl #(.TIMEOUT_CYCLES(TO), .TO_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: phase 0=A, 1=B, 2=done; digits held as a plain list.
  int mPhase;
  int mDigits[$];
  int mOpA, mOpB, mIdle;
  bit mValid, mErr;

  function automatic int digitValue();
    if (mDigits.size() == 2) return mDigits[0] * 10 + mDigits[1];
    if (mDigits.size() == 1) return mDigits[0];
    return 0;
  endfunction

  task automatic modelReset();
    mPhase = 0; mDigits.delete(); mOpA = 0; mOpB = 0; mIdle = 0; mValid = 0; mErr = 0;
  endtask

  task automatic modelStep(input bit kv, input int code, input bit rdy);
    int  prePhase, v;
    bit  active, fire;
    prePhase = mPhase;
    active   = (mPhase == 0 && mDigits.size() > 0) || mPhase == 1;
    fire     = 0;
    if (kv) mIdle = 0;
    else if (active) begin
      mIdle++;
      if (mIdle == TO) fire = 1;
    end else mIdle = 0;
    mErr = 0;
    if (mValid && rdy) begin
      mValid = 0;
      mPhase = 0;
    end
    if (kv && prePhase != 2) begin
      if (code <= 9) begin
        if (mDigits.size() == 2) mErr = 1;
        else mDigits.push_back(code);
      end else if (code == 10) begin
        v = digitValue();
        mDigits.delete();
        if (prePhase == 0) begin
          mOpA = v; mPhase = 1;
        end else begin
          mOpB = v; mPhase = 2; mValid = 1;
        end
      end else if (code != 11) mErr = 1;
    end
    if ((kv && code == 11) || fire) begin
      mDigits.delete(); mOpA = 0; mOpB = 0; mValid = 0; mPhase = 0; mIdle = 0;
    end
  endtask

  task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    cmp({tag, ".ops_valid"}, {7'b0, bus.ops_valid}, {7'b0, mValid});
    cmp({tag, ".op_a"}, bus.op_a, 8'(mOpA));
    cmp({tag, ".op_b"}, bus.op_b, 8'(mOpB));
    cmp({tag, ".disp_tens"}, {4'b0, bus.disp_tens},
        8'((mDigits.size() == 2) ? mDigits[0] : 0));
    cmp({tag, ".disp_unit"}, {4'b0, bus.disp_unit},
        8'((mDigits.size() == 0) ? 0 : mDigits[mDigits.size() - 1]));
    cmp({tag, ".state"}, {6'b0, bus.state}, 8'(mPhase));
    cmp({tag, ".key_err"}, {7'b0, bus.key_err}, {7'b0, mErr});
  endtask

  task automatic applyStimulus(input string tag, input bit kv, input logic [3:0] code,
                               input bit rdy);
    bus.key_valid = kv;
    bus.key_code  = code;
    bus.ops_ready = rdy;
    @(posedge clk);
    modelStep(kv, int'(code), rdy);
    #1;
    bus.key_valid = 1'b0;
    bus.ops_ready = 1'b0;
    checkOutput(tag);
  endtask

  task automatic keyPress(input string tag, input logic [3:0] code, input bit rdy);
    applyStimulus(tag, 1'b1, code, rdy);
  endtask

  task automatic idle(input string tag, input int n, input bit rdy);
    for (int i = 0; i < n; i++) applyStimulus(tag, 1'b0, 4'h0, rdy);
  endtask

  initial begin
    logic [3:0] code;
    int         r;
    bit         kv;

    rst_n         = 1'b0;
    bus.key_valid = 1'b0;
    bus.key_code  = 4'h0;
    bus.ops_ready = 1'b0;
    modelReset();
    #12;
    checkOutput("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Basic A=42, B=7 with consumer always ready.
    keyPress("t1", 4'd4, 1); keyPress("t1", 4'd2, 1); keyPress("t1", 4'hA, 1);
    keyPress("t1", 4'd7, 1); keyPress("t1", 4'hA, 1);
    cmp("t1.op_a42", bus.op_a, 8'd42);
    cmp("t1.op_b7", bus.op_b, 8'd7);
    idle("t1.xfer", 2, 1);

    // Third digit overflows.
    keyPress("t2", 4'd1, 0); keyPress("t2", 4'd2, 0); keyPress("t2", 4'd3, 0);
    cmp("t2.err", {7'b0, bus.key_err}, 8'd1);
    keyPress("t2", 4'hA, 0);
    cmp("t2.op_a12", bus.op_a, 8'd12);
    keyPress("t2.inv", 4'hE, 0);
    keyPress("t2", 4'hB, 0);

    // Max operands, consumer stalls 20 cycles, then one transfer.
    keyPress("t3", 4'd9, 0); keyPress("t3", 4'd9, 0); keyPress("t3", 4'hA, 0);
    keyPress("t3", 4'd9, 0); keyPress("t3", 4'd9, 0); keyPress("t3", 4'hA, 0);
    idle("t3.hold", 20, 0);
    keyPress("t3.done_key", 4'd5, 0);
    keyPress("t3.done_inv", 4'hD, 0);
    cmp("t3.op_b99", bus.op_b, 8'd99);
    idle("t3.xfer", 1, 1);
    idle("t3.after", 2, 1);

    // Idle timeout after a single digit.
    keyPress("t4", 4'd5, 0);
    idle("t4.wait", TO - 1, 0);
    cmp("t4.pre_unit", {4'b0, bus.disp_unit}, 8'd5);
    idle("t4.fire", 1, 0);
    cmp("t4.post_unit", {4'b0, bus.disp_unit}, 8'd0);

    // CLEAR coincides with transfer.
    keyPress("t5", 4'd3, 0); keyPress("t5", 4'hA, 0);
    keyPress("t5", 4'd4, 0); keyPress("t5", 4'hA, 0);
    keyPress("t5.clr", 4'hB, 1);
    cmp("t5.op_a0", bus.op_a, 8'd0);

    // Asynchronous reset mid-entry.
    keyPress("t6", 4'd8, 0);
    #2 rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("t6.async");
    @(negedge clk);
    rst_n = 1'b1;
    keyPress("t6", 4'hA, 0);

    // Random traffic, with occasional long idle stretches to exercise timeouts.
    for (int n = 0; n < 800; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 60)      code = 4'($urandom_range(0, 9));
      else if (r < 80) code = 4'hA;
      else if (r < 85) code = 4'hB;
      else             code = 4'($urandom_range(12, 15));
      kv = ($urandom_range(0, 99) < 60);
      applyStimulus("rand", kv, code, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 99) < 3) idle("rand.idle", TO + 2, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
